alu_mdu_seq: RTL and testbench

- Parametrised successor to the combinational integer ALU: XLEN-wide execute unit with registered output.
- Covers the RV base ALU op set plus the RV M-extension (multiply/divide/remainder).
- Sits in the EX stage behind a valid/ready handshake; divide/remainder are iterative (radix-2, one quotient bit per cycle); all other ops complete in one cycle.

---
 rtl/alu_mdu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_mdu_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mdu_seq.sv
// XLEN-wide RV base ALU + M-extension execute unit. Single-cycle ALU and multiply,
// radix-2 restoring divide, registered result behind valid/ready handshakes.
module alu_mdu_seq #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            illegal_op,
   output logic            busy
);
   localparam int SHW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
   localparam logic [SHW-1:0]  LAST_IT  = SHW'(XLEN - 1);

   localparam logic [4:0] OP_ADD    = 5'b00000, OP_SUB  = 5'b00001, OP_SLL  = 5'b00010;
   localparam logic [4:0] OP_SLT    = 5'b00011, OP_SLTU = 5'b00100, OP_XOR  = 5'b00101;
   localparam logic [4:0] OP_SRL    = 5'b00110, OP_SRA  = 5'b00111, OP_OR   = 5'b01000;
   localparam logic [4:0] OP_AND    = 5'b01001, OP_MUL  = 5'b10000, OP_MULH = 5'b10001;
   localparam logic [4:0] OP_MULHSU = 5'b10010, OP_MULHU = 5'b10011, OP_DIV = 5'b10100;
   localparam logic [4:0] OP_DIVU   = 5'b10101, OP_REM  = 5'b10110, OP_REMU = 5'b10111;

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   state_t                 state_q, state_d;
   logic [XLEN-1:0]        result_q, result_d;
   logic                   illegal_q, illegal_d;
   logic [XLEN-1:0]        rem_q, quo_q, dvs_q;
   logic [SHW-1:0]         cnt_q;
   logic                   negq_q, negr_q, isrem_q;

   logic                   accept;
   logic [SHW-1:0]         shamt;
   logic signed [2*XLEN-1:0] mul_a, mul_b, prod;
   logic                   div_op, div_signed, a_neg, b_neg, div_special, go_div, op_legal;
   logic [XLEN-1:0]        fast_res;
   logic [XLEN:0]          shl, diff;
   logic [XLEN-1:0]        rem_nx, quo_nx, div_res;
   logic                   div_last;

   assign accept = in_valid & in_ready;

   // Single-cycle path: ALU, full-width multiply and divide special cases
   always_comb begin
      shamt       = in_b[SHW-1:0];
      mul_a       = {{XLEN{((op == OP_MULH) | (op == OP_MULHSU)) & in_a[XLEN-1]}}, in_a};
      mul_b       = {{XLEN{(op == OP_MULH) & in_b[XLEN-1]}}, in_b};
      prod        = mul_a * mul_b;
      div_op      = (op[4:2] == 3'b101);
      div_signed  = ~op[0];
      a_neg       = div_signed & in_a[XLEN-1];
      b_neg       = div_signed & in_b[XLEN-1];
      div_special = (in_b == '0) | (div_signed & (in_a == MIN_NEG) & (in_b == ALL_ONES));
      go_div      = div_op & ~div_special;
      op_legal    = 1'b1;
      fast_res    = '0;
      case (op)
         OP_ADD:    fast_res = in_a + in_b;
         OP_SUB:    fast_res = in_a - in_b;
         OP_SLL:    fast_res = in_a << shamt;
         OP_SLT:    fast_res = XLEN'($signed(in_a) < $signed(in_b));
         OP_SLTU:   fast_res = XLEN'(in_a < in_b);
         OP_XOR:    fast_res = in_a ^ in_b;
         OP_SRL:    fast_res = in_a >> shamt;
         OP_SRA:    fast_res = $unsigned($signed(in_a) >>> shamt);
         OP_OR:     fast_res = in_a | in_b;
         OP_AND:    fast_res = in_a & in_b;
         OP_MUL:    fast_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:
                    fast_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:
                    fast_res = (in_b == '0) ? ALL_ONES : in_a;
         OP_REM, OP_REMU:
                    fast_res = (in_b == '0) ? in_a : '0;
         default:   op_legal = 1'b0;
      endcase
   end

   // One restoring step per cycle on magnitudes; signs are fixed up on the last step
   always_comb begin
      shl      = {rem_q, quo_q[XLEN-1]};
      diff     = shl - {1'b0, dvs_q};
      rem_nx   = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
      quo_nx   = {quo_q[XLEN-2:0], ~diff[XLEN]};
      div_res  = isrem_q ? cond_neg(rem_nx, negr_q) : cond_neg(quo_nx, negq_q);
      div_last = (state_q == S_DIV) & (cnt_q == LAST_IT);
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (accept) state_d = go_div ? S_DIV : S_DONE;
         S_DIV:  if (cnt_q == LAST_IT) state_d = S_DONE;
         S_DONE: if (out_ready) state_d = accept ? (go_div ? S_DIV : S_DONE) : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
      out_valid = (state_q == S_DONE);
      busy      = (state_q == S_DIV);
   end

   always_comb begin
      result_d  = result_q;
      illegal_d = illegal_q;
      if (accept & ~go_div) begin
         result_d  = fast_res;
         illegal_d = ~op_legal;
      end else if (div_last) begin
         result_d  = div_res;
         illegal_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q  <= '0;
         illegal_q <= 1'b0;
      end else begin
         result_q  <= result_d;
         illegal_q <= illegal_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         rem_q   <= '0;
         quo_q   <= cond_neg(in_a, a_neg);
         dvs_q   <= cond_neg(in_b, b_neg);
         cnt_q   <= '0;
         negq_q  <= a_neg ^ b_neg;
         negr_q  <= a_neg;
         isrem_q <= op[1];
      end else if (state_q == S_DIV) begin
         rem_q   <= rem_nx;
         quo_q   <= quo_nx;
         cnt_q   <= cnt_q + SHW'(1);
      end
   end

   assign result     = result_q;
   assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Scoreboard bench for alu_mdu_seq, exercising XLEN = 32 and XLEN = 64 instances side by side.
module tb_alu_mdu_seq;
   typedef struct {
      string       nm;
      logic [63:0] res;
      logic        ill;
      int          lat;
      int          acc;
   } exp_t;

   localparam logic [4:0] T_ADD = 5'b00000, T_SUB = 5'b00001, T_SLL = 5'b00010, T_SLT = 5'b00011;
   localparam logic [4:0] T_SLTU = 5'b00100, T_XOR = 5'b00101, T_SRL = 5'b00110, T_SRA = 5'b00111;
   localparam logic [4:0] T_OR = 5'b01000, T_AND = 5'b01001, T_MUL = 5'b10000, T_MULH = 5'b10001;
   localparam logic [4:0] T_MULHSU = 5'b10010, T_MULHU = 5'b10011, T_DIV = 5'b10100;
   localparam logic [4:0] T_DIVU = 5'b10101, T_REM = 5'b10110, T_REMU = 5'b10111;

   logic clk;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_done = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int w, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL xlen%0d %s: got 0x%0h, expected 0x%0h", w, nm, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_w
      localparam int W  = (g == 0) ? 32 : 64;
      localparam int LD = W + 1;
      localparam logic [W-1:0] ONES  = {W{1'b1}};
      localparam logic [W-1:0] MINN  = {1'b1, {(W-1){1'b0}}};
      localparam logic [W-1:0] MAXP  = {1'b0, {(W-1){1'b1}}};
      localparam logic [W-1:0] SRA_E = {2'b11, {(W-2){1'b0}}};
      localparam logic [W-1:0] SRL_E = {2'b01, {(W-2){1'b0}}};
      localparam logic [W-1:0] HALF  = {{(W/2-1){1'b0}}, 1'b1, {(W/2){1'b0}}};
      localparam logic [W-1:0] M7    = ~W'(6);
      localparam logic [W-1:0] M3    = ~W'(2);
      localparam logic [W-1:0] M2    = ~W'(1);

      logic         rst_s, ivld_s, ordy_s;
      logic [4:0]   op_s;
      logic [W-1:0] a_s, b_s, res_o;
      logic         ird_o, vld_o, ill_o, busy_o;
      exp_t         sb[$];

      alu_mdu_seq #(.XLEN(W)) dut (
         .clk       (clk),
         .rst       (rst_s),
         .in_valid  (ivld_s),
         .in_ready  (ird_o),
         .op        (op_s),
         .in_a      (a_s),
         .in_b      (b_s),
         .out_valid (vld_o),
         .out_ready (ordy_s),
         .result    (res_o),
         .illegal_op(ill_o),
         .busy      (busy_o)
      );

      task automatic issue(input string nm, input logic [4:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] e, input logic il,
                           input int lat, input bit push);
         bit   ok;
         exp_t ex;
         ivld_s = 1'b1;
         op_s   = o;
         a_s    = x;
         b_s    = y;
         ok     = 1'b0;
         for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (ird_o) begin
               ok = 1'b1;
               break;
            end
         end
         chk({nm, "_accept"}, W, 64'(ok), 64'd1);
         if (push && ok) begin
            ex.nm  = nm;
            ex.res = 64'(e);
            ex.ill = il;
            ex.lat = lat;
            ex.acc = cyc + 1;
            sb.push_back(ex);
         end
         @(posedge clk);
         #1;
         ivld_s = 1'b0;
      endtask

      task automatic drain(input string nm);
         for (int i = 0; i < 400; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
         end
         chk({nm, "_drain"}, W, 64'(sb.size()), 64'd0);
         @(posedge clk);
         #1;
      endtask

      initial begin : mon
         exp_t e;
         bit   seen;
         int   first_c;
         seen    = 1'b0;
         first_c = 0;
         forever begin
            @(negedge clk);
            if (rst_s) begin
               seen = 1'b0;
            end else if (vld_o) begin
               if (!seen) begin
                  seen    = 1'b1;
                  first_c = cyc;
               end
               if (ordy_s) begin
                  seen = 1'b0;
                  chk("sb_has_entry", W, 64'(sb.size() != 0), 64'd1);
                  if (sb.size() != 0) begin
                     e = sb.pop_front();
                     chk({e.nm, "_result"}, W, 64'(res_o), e.res);
                     chk({e.nm, "_illegal"}, W, 64'(ill_o), 64'(e.ill));
                     chk({e.nm, "_latency"}, W, 64'(first_c + 1 - e.acc), 64'(e.lat));
                  end
               end
            end
         end
      end

      initial begin : drv
         int nb, bad, nv;
         bit seen_v;
         rst_s  = 1'b1;
         ivld_s = 1'b0;
         ordy_s = 1'b1;
         op_s   = '0;
         a_s    = '0;
         b_s    = '0;
         repeat (3) @(posedge clk);
         #1;
         rst_s = 1'b0;
         chk("rst_out_valid", W, 64'(vld_o), 64'd0);
         chk("rst_in_ready", W, 64'(ird_o), 64'd1);
         chk("rst_busy", W, 64'(busy_o), 64'd0);
         chk("rst_result", W, 64'(res_o), 64'd0);
         chk("rst_illegal", W, 64'(ill_o), 64'd0);

         issue("add_ovf", T_ADD, MAXP, W'(1), MINN, 1'b0, 1, 1'b1);
         issue("sub_0_1", T_SUB, W'(0), W'(1), ONES, 1'b0, 1, 1'b1);
         issue("sra", T_SRA, MINN, W'(W + 1), SRA_E, 1'b0, 1, 1'b1);
         issue("srl", T_SRL, MINN, W'(W + 1), SRL_E, 1'b0, 1, 1'b1);
         issue("sll", T_SLL, W'(1), W'(W + 3), W'(8), 1'b0, 1, 1'b1);
         issue("sltu", T_SLTU, W'(1), ONES, W'(1), 1'b0, 1, 1'b1);
         issue("slt", T_SLT, W'(1), ONES, W'(0), 1'b0, 1, 1'b1);
         issue("slt_neg", T_SLT, ONES, W'(1), W'(1), 1'b0, 1, 1'b1);
         issue("xor", T_XOR, W'(16'hF0F0), W'(16'hFF00), W'(16'h0FF0), 1'b0, 1, 1'b1);
         issue("or", T_OR, W'(16'hF0F0), W'(16'hFF00), W'(16'hFFF0), 1'b0, 1, 1'b1);
         issue("and", T_AND, W'(16'hF0F0), W'(16'hFF00), W'(16'hF000), 1'b0, 1, 1'b1);
         issue("ill_01111", 5'b01111, W'(5), W'(6), W'(0), 1'b1, 1, 1'b1);
         issue("ill_11000", 5'b11000, ONES, ONES, W'(0), 1'b1, 1, 1'b1);
         issue("mulh", T_MULH, ONES, ONES, W'(0), 1'b0, 1, 1'b1);
         issue("mulhu", T_MULHU, ONES, ONES, ~W'(1), 1'b0, 1, 1'b1);
         issue("mulhsu", T_MULHSU, ONES, W'(2), ONES, 1'b0, 1, 1'b1);
         issue("mul_half", T_MUL, HALF, HALF, W'(0), 1'b0, 1, 1'b1);
         issue("mul_neg", T_MUL, W'(7), M3, ~W'(20), 1'b0, 1, 1'b1);

         // Normal divide: busy for exactly W cycles with in_ready held low
         issue("div_m7_2", T_DIV, M7, W'(2), M3, 1'b0, LD, 1'b1);
         nb     = 0;
         bad    = 0;
         seen_v = 1'b0;
         for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (vld_o) begin
               seen_v = 1'b1;
               break;
            end
            if (busy_o) nb++;
            if (ird_o) bad++;
         end
         chk("div_done_seen", W, 64'(seen_v), 64'd1);
         chk("div_busy_cycles", W, 64'(nb), 64'(W));
         chk("div_in_ready_low", W, 64'(bad), 64'd0);
         @(posedge clk);
         #1;

         issue("rem_m7_2", T_REM, M7, W'(2), ONES, 1'b0, LD, 1'b1);
         issue("divu_by0", T_DIVU, W'(7), W'(0), ONES, 1'b0, 1, 1'b1);
         issue("remu_by0", T_REMU, W'(7), W'(0), W'(7), 1'b0, 1, 1'b1);
         issue("div_by0", T_DIV, M7, W'(0), ONES, 1'b0, 1, 1'b1);
         issue("rem_by0", T_REM, M7, W'(0), M7, 1'b0, 1, 1'b1);
         issue("div_ovf", T_DIV, MINN, ONES, MINN, 1'b0, 1, 1'b1);
         issue("rem_ovf", T_REM, MINN, ONES, W'(0), 1'b0, 1, 1'b1);
         issue("divu_100_7", T_DIVU, W'(100), W'(7), W'(14), 1'b0, LD, 1'b1);
         issue("remu_100_7", T_REMU, W'(100), W'(7), W'(2), 1'b0, LD, 1'b1);
         issue("div_7_m2", T_DIV, W'(7), M2, M3, 1'b0, LD, 1'b1);
         issue("rem_7_m2", T_REM, W'(7), M2, W'(1), 1'b0, LD, 1'b1);
         issue("divu_max", T_DIVU, ONES, W'(1), ONES, 1'b0, LD, 1'b1);
         drain("main");

         // Back-pressure: result held stable in DONE, then released with a new request
         ordy_s = 1'b0;
         issue("bp_hold", T_ADD, W'(5), W'(6), W'(11), 1'b0, 1, 1'b1);
         repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid", W, 64'(vld_o), 64'd1);
            chk("bp_result", W, 64'(res_o), 64'd11);
            chk("bp_in_ready", W, 64'(ird_o), 64'd0);
         end
         @(posedge clk);
         #1;
         ordy_s = 1'b1;
         issue("bp_next", T_ADD, W'(2), W'(3), W'(5), 1'b0, 1, 1'b1);
         drain("bp");

         // Reset in the middle of a divide discards it
         issue("divu_abort", T_DIVU, W'(100), W'(7), W'(0), 1'b0, 0, 1'b0);
         repeat (9) @(posedge clk);
         #1;
         rst_s = 1'b1;
         @(posedge clk);
         #1;
         rst_s = 1'b0;
         chk("abort_out_valid", W, 64'(vld_o), 64'd0);
         chk("abort_busy", W, 64'(busy_o), 64'd0);
         chk("abort_result", W, 64'(res_o), 64'd0);
         chk("abort_illegal", W, 64'(ill_o), 64'd0);
         chk("abort_in_ready", W, 64'(ird_o), 64'd1);
         nv = 0;
         repeat (40) begin
            @(negedge clk);
            if (vld_o) nv++;
         end
         chk("abort_no_valid", W, 64'(nv), 64'd0);
         @(posedge clk);
         #1;
         issue("add_after_rst", T_ADD, W'(3), W'(4), W'(7), 1'b0, 1, 1'b1);
         drain("end");
         n_done++;
      end
   end

   initial begin : fin
      for (int i = 0; i < 20000; i++) begin
         @(posedge clk);
         if (n_done == 2) break;
      end
      chk("all_sequences_done", 0, 64'(n_done), 64'd2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
